// File: rtl/vec_exec_pkg.sv
// Shared opcode, stage-payload and helper definitions for the vector execute unit.
package vec_exec_pkg;

    localparam int LATENCY = 3;
    localparam int OP_W    = 5;

    typedef enum logic [OP_W-1:0] {
        ADD    = 5'd0,
        SUB    = 5'd1,
        ADDS   = 5'd2,
        SUBS   = 5'd3,
        MUL    = 5'd4,
        AND    = 5'd5,
        OR     = 5'd6,
        XOR    = 5'd7,
        SLL    = 5'd8,
        SRA    = 5'd9,
        MIN    = 5'd10,
        MAX    = 5'd11,
        REDSUM = 5'd12,
        BCAST  = 5'd13
    } vop_e;

    typedef struct packed {
        vop_e op;
        logic illegal;
    } stage_ctl_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_W'(BCAST);
    endfunction

    function automatic int shamt_w(input int lane_w);
        return (lane_w > 1) ? $clog2(lane_w) : 1;
    endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational datapath: wrapping/saturating arithmetic, multiply, logic, shifts, min/max.
module vec_lane_alu
    import vec_exec_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int SH_W   = 3
) (
    input  vop_e                     op,
    input  logic signed [LANE_W-1:0] a,
    input  logic signed [LANE_W-1:0] b,
    input  logic [SH_W-1:0]          shamt,
    output logic signed [LANE_W-1:0] result,
    output logic                     sat
);

    logic signed [LANE_W:0]     sum_w;
    logic signed [LANE_W:0]     diff_w;
    logic signed [2*LANE_W-1:0] prod_w;
    logic [LANE_W:0]            clamp_r;

    // Returns {clamped, value}; overflow shows as disagreement of the two top bits.
    function automatic logic [LANE_W:0] sat_clamp(input logic signed [LANE_W:0] w);
        if (w[LANE_W] != w[LANE_W-1]) begin
            return {1'b1, w[LANE_W], {(LANE_W-1){~w[LANE_W]}}};
        end
        return {1'b0, w[LANE_W-1:0]};
    endfunction

    assign sum_w  = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    assign diff_w = {a[LANE_W-1], a} - {b[LANE_W-1], b};
    assign prod_w = a * b;

    always_comb begin
        result  = '0;
        sat     = 1'b0;
        clamp_r = '0;
        case (op)
            ADD:  result = sum_w[LANE_W-1:0];
            SUB:  result = diff_w[LANE_W-1:0];
            ADDS: begin
                clamp_r = sat_clamp(sum_w);
                result  = clamp_r[LANE_W-1:0];
                sat     = clamp_r[LANE_W];
            end
            SUBS: begin
                clamp_r = sat_clamp(diff_w);
                result  = clamp_r[LANE_W-1:0];
                sat     = clamp_r[LANE_W];
            end
            MUL:  result = prod_w[LANE_W-1:0];
            AND:  result = a & b;
            OR:   result = a | b;
            XOR:  result = a ^ b;
            SLL:  result = a << shamt;
            SRA:  result = a >>> shamt;
            MIN:  result = (a < b) ? a : b;
            MAX:  result = (a > b) ? a : b;
            default: ;
        endcase
    end

endmodule

// File: rtl/vec_exec_unit.sv
// Three-stage SIMD execute unit with valid/ready on both sides and an in-flight flush.
module vec_exec_unit
    import vec_exec_pkg::*;
#(
    parameter int LANES  = 6,
    parameter int LANE_W = 8,
    parameter int RD_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [LANES*LANE_W-1:0]   in_a,
    input  logic [LANES*LANE_W-1:0]   in_b,
    input  logic [RD_W-1:0]           in_rd,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   out_result,
    output logic [LANES-1:0]          out_sat,
    output logic                      out_illegal,
    output logic [RD_W-1:0]           out_rd
);

    localparam int VW   = LANES * LANE_W;
    localparam int SH_W = shamt_w(LANE_W);

    logic vld_p1, vld_p2, vld_p3;
    logic load_p1, load_p2, load_p3;

    stage_ctl_t      ctl_p1;
    logic [VW-1:0]   a_p1, b_p1;
    logic [RD_W-1:0] rd_p1;

    logic [VW-1:0]    res_p2;
    logic [LANES-1:0] sat_p2;
    logic             ill_p2;
    logic [RD_W-1:0]  rd_p2;

    logic [VW-1:0]     lane_res, res_c;
    logic [LANES-1:0]  lane_sat, sat_c;
    logic [LANE_W-1:0] red_sum;

    // A stage may load when empty or when its successor is loading; output drains on out_ready.
    assign load_p3   = !vld_p3 || out_ready;
    assign load_p2   = !vld_p2 || load_p3;
    assign load_p1   = !vld_p1 || load_p2;
    assign in_ready  = !flush && load_p1;
    assign out_valid = vld_p3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            vld_p3      <= 1'b0;
            out_result  <= '0;
            out_sat     <= '0;
            out_illegal <= 1'b0;
            out_rd      <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
                vld_p3 <= 1'b0;
            end else begin
                if (load_p1) vld_p1 <= in_valid;
                if (load_p2) vld_p2 <= vld_p1;
                if (load_p3) vld_p3 <= vld_p2;
            end
            // ---- S3: output register ----
            if (load_p3) begin
                out_result  <= res_p2;
                out_sat     <= sat_p2;
                out_illegal <= ill_p2;
                out_rd      <= rd_p2;
            end
        end
    end

    // ---- S1: operand capture ----
    always_ff @(posedge clk) begin
        if (load_p1) begin
            ctl_p1 <= '{op: vop_e'(in_op), illegal: !op_is_legal(in_op)};
            a_p1   <= in_a;
            b_p1   <= in_b;
            rd_p1  <= in_rd;
        end
    end

    // ---- S2: lane compute, reduction and broadcast ----
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vec_lane_alu #(
            .LANE_W (LANE_W),
            .SH_W   (SH_W)
        ) u_lane_alu (
            .op     (ctl_p1.op),
            .a      (a_p1[i*LANE_W +: LANE_W]),
            .b      (b_p1[i*LANE_W +: LANE_W]),
            .shamt  (b_p1[SH_W-1:0]),
            .result (lane_res[i*LANE_W +: LANE_W]),
            .sat    (lane_sat[i])
        );
    end

    always_comb begin
        red_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            red_sum = red_sum + a_p1[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        res_c = lane_res;
        sat_c = lane_sat;
        case (ctl_p1.op)
            REDSUM: begin
                res_c = VW'(red_sum);
                sat_c = '0;
            end
            BCAST: begin
                res_c = {LANES{a_p1[LANE_W-1:0]}};
                sat_c = '0;
            end
            default: ;
        endcase
        if (ctl_p1.illegal) begin
            res_c = '0;
            sat_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p2) begin
            res_p2 <= res_c;
            sat_p2 <= sat_c;
            ill_p2 <= ctl_p1.illegal;
            rd_p2  <= rd_p1;
        end
    end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Scoreboard bench for vec_exec_unit: directed ops, backpressure, flush and async reset.
module tb_vec_exec_unit;
    import vec_exec_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [47:0] in_a;
    logic [47:0] in_b;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_result;
    logic [5:0]  out_sat;
    logic        out_illegal;
    logic [4:0]  out_rd;

    typedef struct {
        logic [47:0] res;
        logic [5:0]  sat;
        logic        ill;
        logic [4:0]  rd;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    vec_exec_unit #(.LANES(6), .LANE_W(8), .RD_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_rd       (in_rd),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_sat     (out_sat),
        .out_illegal (out_illegal),
        .out_rd      (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; holds the op until accepted, then returns on a falling edge.
    task automatic offer(input logic [4:0] op, input logic [47:0] a, input logic [47:0] b,
                         input logic [4:0] rd, input logic [47:0] er, input logic [5:0] es,
                         input logic ei, input bit lat);
        exp_t e;
        bit   done;
        int   n;
        done = 0;
        n    = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
        while (!done && n < 50) begin
            #2;
            if (in_ready) begin
                e.res = er; e.sat = es; e.ill = ei; e.rd = rd; e.acc = cyc; e.lat = lat;
                sb.push_back(e);
                done = 1;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops an expectation on every output transfer, and checks hold stability under stall.
    initial begin
        exp_t        e;
        logic [59:0] held;
        bit          hv;
        hv = 0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hv = 0;
            end else begin
                if (out_valid && !out_ready) begin
                    if (hv) chk("hold_stable", 64'({out_illegal, out_rd, out_sat, out_result}), 64'(held));
                    held = {out_illegal, out_rd, out_sat, out_result};
                    hv = 1;
                end else begin
                    hv = 0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", {63'd0, out_valid}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", 64'(out_result), 64'(e.res));
                        chk("sat", 64'(out_sat), 64'(e.sat));
                        chk("illegal", 64'(out_illegal), 64'(e.ill));
                        chk("rd", 64'(out_rd), 64'(e.rd));
                        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
        flush = 1'b0; out_ready = 1'b1;

        @(negedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Streaming directed ops, out_ready held high
        offer(5'(ADD),    48'h060504030201, 48'h101010101010, 5'd1, 48'h161514131211, 6'b000000, 1'b0, 1);
        offer(5'(ADDS),   48'h00000000F070, 48'h00000000F020, 5'd2, 48'h00000000E07F, 6'b000001, 1'b0, 1);
        offer(5'(SUBS),   48'h000000000580, 48'h000000000701, 5'd3, 48'h00000000FE80, 6'b000001, 1'b0, 1);
        offer(5'(SUB),    48'h000000000080, 48'h000000000001, 5'd4, 48'h00000000007F, 6'b000000, 1'b0, 1);
        offer(5'(MUL),    48'h00000010FE03, 48'h000000100705, 5'd5, 48'h00000000F20F, 6'b000000, 1'b0, 1);
        offer(5'(SRA),    48'h00000080F040, 48'h00000000000A, 5'd6, 48'h000000E0FC10, 6'b000000, 1'b0, 1);
        offer(5'(SLL),    48'h000000008101, 48'h000000000003, 5'd7, 48'h000000000808, 6'b000000, 1'b0, 1);
        offer(5'(MIN),    48'h000000000580, 48'h00000000037F, 5'd8, 48'h000000000380, 6'b000000, 1'b0, 1);
        offer(5'(MAX),    48'h000000000580, 48'h00000000037F, 5'd9, 48'h00000000057F, 6'b000000, 1'b0, 1);
        offer(5'(AND),    48'hFF00F0F0AA55, 48'h0F0FFF00FF00, 5'd10, 48'h0F00F000AA00, 6'b000000, 1'b0, 1);
        offer(5'(OR),     48'hFF00F0F0AA55, 48'h0F0FFF00FF00, 5'd11, 48'hFF0FFFF0FF55, 6'b000000, 1'b0, 1);
        offer(5'(XOR),    48'hFF00F0F0AA55, 48'h0F0FFF00FF00, 5'd12, 48'hF00F0FF05555, 6'b000000, 1'b0, 1);
        offer(5'(REDSUM), 48'h404040404040, 48'h123456789ABC, 5'd13, 48'h000000000080, 6'b000000, 1'b0, 1);
        offer(5'(BCAST),  48'h11223344555A, 48'h000000000000, 5'd14, 48'h5A5A5A5A5A5A, 6'b000000, 1'b0, 1);
        offer(5'd20,      48'h7F7F7F7F7F7F, 48'h7F7F7F7F7F7F, 5'd15, 48'h000000000000, 6'b000000, 1'b1, 1);
        drain();

        // Backpressure: three fill the pipe, the fourth is refused until the output drains
        out_ready = 1'b0;
        offer(5'(ADD), 48'h000000000001, 48'h000000000001, 5'd16, 48'h000000000002, 6'b0, 1'b0, 0);
        offer(5'(ADD), 48'h000000000002, 48'h000000000002, 5'd17, 48'h000000000004, 6'b0, 1'b0, 0);
        offer(5'(ADD), 48'h000000000003, 48'h000000000003, 5'd18, 48'h000000000006, 6'b0, 1'b0, 0);
        in_valid = 1'b1; in_op = 5'(ADD); in_a = 48'h4; in_b = 48'h4; in_rd = 5'd19;
        #2;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #2;
        chk("full_in_ready_2", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        offer(5'(ADD), 48'h000000000004, 48'h000000000004, 5'd19, 48'h000000000008, 6'b0, 1'b0, 0);
        offer(5'(ADD), 48'h000000000005, 48'h000000000005, 5'd20, 48'h00000000000A, 6'b0, 1'b0, 0);
        drain();

        // Flush with three in flight; the op offered alongside flush must be refused
        out_ready = 1'b0;
        offer(5'(ADD), 48'h000000000011, 48'h000000000011, 5'd21, 48'h000000000022, 6'b0, 1'b0, 0);
        offer(5'(ADD), 48'h000000000012, 48'h000000000012, 5'd22, 48'h000000000024, 6'b0, 1'b0, 0);
        offer(5'(ADD), 48'h000000000013, 48'h000000000013, 5'd23, 48'h000000000026, 6'b0, 1'b0, 0);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 5'(ADD); in_a = 48'h77; in_b = 48'h1; in_rd = 5'd24;
        #2;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #2;
            chk("flush_gone", 64'(out_valid), 64'd0);
        end
        @(negedge clk);

        // Asynchronous reset while a result is held at the output
        out_ready = 1'b0;
        offer(5'(BCAST), 48'h00000000005A, 48'h0, 5'd7, 48'h5A5A5A5A5A5A, 6'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_result", 64'(out_result), 64'd0);
        chk("arst_out_sat", 64'(out_sat), 64'd0);
        chk("arst_out_illegal", 64'(out_illegal), 64'd0);
        chk("arst_out_rd", 64'(out_rd), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        offer(5'(ADD), 48'h0A0A0A0A0A0A, 48'h010203040506, 5'd9, 48'h0B0C0D0E0F10, 6'b0, 1'b0, 1);
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
